// File: rtl/systolic_pkg.sv
// ============================================================================
// Module      : systolic_pkg
// Description : Shared sizes, lane type and feeder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

    localparam int N              = 4;
    localparam int DATA_W         = 8;
    localparam int LANE_LEN       = 2*N - 1;
    localparam int PROCESS_CYCLES = 3*N - 2;
    localparam int CNT_W          = 4;

    typedef logic [LANE_LEN-1:0][DATA_W-1:0] lane_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/feeder_lane.sv
// ============================================================================
// Module      : feeder_lane
// Description : Parallel-load lane that shifts toward slot 0 with zero fill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module feeder_lane
    import systolic_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_arst,
    input  logic  i_load,
    input  logic  i_shift,
    input  lane_t i_data,
    output lane_t o_data
);

    lane_t slot_q;
    lane_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (i_load) begin
            slot_d = i_data;
        end else if (i_shift) begin
            // Top slot refills with zero so trailing cycles feed no operands.
            slot_d = {DATA_W'(0), slot_q[LANE_LEN-1:1]};
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign o_data = slot_q;

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ============================================================================
// Module      : systolic_feeder
// Description : Captures A/B and streams skewed operands into a 4x4 array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_feeder
    import systolic_pkg::*;
(
    input  logic                                     i_clk,
    input  logic                                     i_arst,
    input  logic                                     i_valid,
    output logic                                     o_ready,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]          i_a,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]          i_b,
    output logic [N-1:0][LANE_LEN-1:0][DATA_W-1:0]   o_row,
    output logic [N-1:0][LANE_LEN-1:0][DATA_W-1:0]   o_col,
    output logic                                     o_doProcess,
    output logic                                     o_done
);

    feeder_state_e    state_q;
    feeder_state_e    state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load;
    logic             shift;

    lane_t [N-1:0] row_load;
    lane_t [N-1:0] col_load;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        o_ready     = 1'b0;
        o_doProcess = 1'b0;
        o_done      = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                o_doProcess = 1'b1;
                shift       = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(PROCESS_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane l is delayed by l slots: operand k of lane l sits in slot l+k.
    for (genvar l = 0; l < N; l++) begin : g_skew_lane
        for (genvar s = 0; s < LANE_LEN; s++) begin : g_skew_slot
            if (s >= l && s < l + N) begin : g_operand
                assign row_load[l][s] = i_a[l][s-l];
                assign col_load[l][s] = i_b[s-l][l];
            end else begin : g_zero
                assign row_load[l][s] = '0;
                assign col_load[l][s] = '0;
            end
        end
    end

    for (genvar l = 0; l < N; l++) begin : g_lane
        feeder_lane u_row_lane (
            .i_clk   (i_clk),
            .i_arst  (i_arst),
            .i_load  (load),
            .i_shift (shift),
            .i_data  (row_load[l]),
            .o_data  (o_row[l])
        );

        feeder_lane u_col_lane (
            .i_clk   (i_clk),
            .i_arst  (i_arst),
            .i_load  (load),
            .i_shift (shift),
            .i_data  (col_load[l]),
            .o_data  (o_col[l])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ============================================================================
// Module      : tb_systolic_feeder
// Description : Self-checking bench for systolic_feeder with a 4x4 array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_feeder;
    import systolic_pkg::*;

    typedef logic [3:0][3:0][7:0] mat_t;

    typedef struct {
        int         cyc;
        bit         is_col;
        int         lane;
        int         slot;
        logic [7:0] exp;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  arst;
    logic                  valid;
    logic                  ready;
    mat_t                  a_in;
    mat_t                  b_in;
    logic [3:0][6:0][7:0]  row;
    logic [3:0][6:0][7:0]  col;
    logic                  dp;
    logic                  done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_feeder dut (
        .i_clk       (clk),
        .i_arst      (arst),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_a         (a_in),
        .i_b         (b_in),
        .o_row       (row),
        .o_col       (col),
        .o_doProcess (dp),
        .o_done      (done)
    );

    // Output-stationary 4x4 array: A flows right, B flows down.
    logic [7:0] ma [4][4];
    logic [7:0] mb [4][4];
    int         mc [4][4];

    always @(posedge clk) begin
        if (ready && valid) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    mc[i][j] <= 0;
                    ma[i][j] <= 8'h00;
                    mb[i][j] <= 8'h00;
                end
        end else if (dp) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    automatic logic [7:0] av;
                    automatic logic [7:0] bv;
                    if (j == 0) av = row[i][0]; else av = ma[i][j-1];
                    if (i == 0) bv = col[j][0]; else bv = mb[i-1][j];
                    ma[i][j] <= av;
                    mb[i][j] <= bv;
                    mc[i][j] <= mc[i][j] + int'(av) * int'(bv);
                end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mat_t mk(input int kind);
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                case (kind)
                    0:       m[r][c] = 8'(16*r + c);
                    1:       m[r][c] = (r == c) ? 8'd1 : 8'd0;
                    2:       m[r][c] = 8'(4*r + c);
                    3:       m[r][c] = 8'd1;
                    default: m[r][c] = 8'd2;
                endcase
        return m;
    endfunction

    task automatic run_pass(input mat_t a, input mat_t b, output int lat, output int dpc);
        int t;
        lat = -1;
        dpc = 0;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        valid = 1'b1;
        t = 0;
        while (!ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        a_in  = '1;
        b_in  = '1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (dp) dpc++;
            if (done && lat < 0) lat = c;
        end
    endtask

    task automatic chk_c(input string tag, input mat_t exp_m, input int kind_full);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("%s_C%0d%0d", tag, i, j), 32'(mc[i][j]),
                    (kind_full >= 0) ? 32'(kind_full) : 32'(exp_m[i][j]));
    endtask

    vec_t tbl[$];
    int   acc[$];
    int   lat;
    int   dpc;
    logic [7:0] pendv;
    bit   pend;
    bit   seen;
    logic [31:0] act;

    initial begin
        // Expected slot contents for A[i][k]=16i+k, B[k][j]=16k+j.
        tbl.push_back('{1, 1'b0, 1, 0, 8'h00});
        tbl.push_back('{1, 1'b0, 1, 1, 8'h10});
        tbl.push_back('{1, 1'b0, 0, 0, 8'h00});
        tbl.push_back('{1, 1'b0, 3, 6, 8'h33});
        tbl.push_back('{1, 1'b1, 2, 0, 8'h00});
        tbl.push_back('{1, 1'b1, 2, 1, 8'h00});
        tbl.push_back('{1, 1'b1, 2, 2, 8'h02});
        tbl.push_back('{1, 1'b1, 2, 5, 8'h32});
        tbl.push_back('{1, 1'b1, 2, 6, 8'h00});
        tbl.push_back('{1, 1'b1, 0, 3, 8'h30});
        tbl.push_back('{2, 1'b0, 1, 0, 8'h10});
        tbl.push_back('{2, 1'b0, 3, 0, 8'h00});
        tbl.push_back('{2, 1'b0, 0, 0, 8'h01});
        tbl.push_back('{4, 1'b0, 3, 0, 8'h30});
        tbl.push_back('{4, 1'b1, 3, 0, 8'h03});
        tbl.push_back('{7, 1'b0, 3, 0, 8'h33});
        tbl.push_back('{8, 1'b0, 3, 0, 8'h00});
        tbl.push_back('{11, 1'b0, 3, 0, 8'h00});

        arst  = 1'b0;
        valid = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #12;
        chk("rst_row", 32'(row != '0), 32'd0);
        chk("rst_col", 32'(col != '0), 32'd0);
        chk("rst_dp", 32'(dp), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);

        // Skew table pass with control timing.
        @(negedge clk);
        a_in  = mk(0);
        b_in  = mk(0);
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        a_in  = '1;
        b_in  = '1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            foreach (tbl[n]) begin
                if (tbl[n].cyc == c) begin
                    act = tbl[n].is_col ? 32'(col[tbl[n].lane][tbl[n].slot])
                                        : 32'(row[tbl[n].lane][tbl[n].slot]);
                    chk($sformatf("%s%0d_s%0d_c%0d", tbl[n].is_col ? "col" : "row",
                                  tbl[n].lane, tbl[n].slot, c), act, 32'(tbl[n].exp));
                end
            end
            chk($sformatf("dp_c%0d", c), 32'(dp), 32'(c <= 10));
            chk($sformatf("done_c%0d", c), 32'(done), 32'(c == 11));
            chk($sformatf("ready_c%0d", c), 32'(ready), 32'(c == 12));
        end

        run_pass(mk(1), mk(2), lat, dpc);
        chk("ident_dp_cycles", 32'(dpc), 32'd10);
        chk("ident_done_lat", 32'(lat), 32'd11);
        chk_c("ident", mk(2), -1);

        run_pass(mk(3), mk(4), lat, dpc);
        chk("ones_done_lat", 32'(lat), 32'd11);
        chk_c("ones", mk(4), 8);

        // Continuous valid with data changing every cycle.
        pend = 1'b0;
        pendv = 8'h00;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (pend) begin
                chk($sformatf("cont_stream_%0d", c), 32'(row[0][0]), 32'(pendv));
                pend = 1'b0;
            end
            a_in  = {16{8'(c + 1)}};
            b_in  = '0;
            valid = 1'b1;
            if (ready) begin
                acc.push_back(c);
                pendv = 8'(c + 1);
                pend  = 1'b1;
            end
        end
        valid = 1'b0;
        chk("cont_accepts", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            chk("cont_first", 32'(acc[0]), 32'd0);
            chk("cont_gap1", 32'(acc[1] - acc[0]), 32'd12);
            chk("cont_gap2", 32'(acc[2] - acc[1]), 32'd12);
        end
        for (int t = 0; t < 30 && !ready; t++) @(negedge clk);
        chk("cont_idle", 32'(ready), 32'd1);

        // Asynchronous reset at cnt=5.
        @(negedge clk);
        a_in  = mk(0);
        b_in  = mk(0);
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_dp", 32'(dp), 32'd1);
        chk("mid_row_busy", 32'(row != '0), 32'd1);
        #2;
        arst = 1'b0;
        #1;
        chk("arst_row", 32'(row != '0), 32'd0);
        chk("arst_col", 32'(col != '0), 32'd0);
        chk("arst_dp", 32'(dp), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || dp) seen = 1'b1;
        end
        chk("arst_no_done", 32'(seen), 32'd0);

        run_pass(mk(3), mk(4), lat, dpc);
        chk("post_rst_lat", 32'(lat), 32'd11);
        chk("post_rst_dp", 32'(dpc), 32'd10);
        chk_c("post_rst", mk(4), 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameters: none; all sizes come from systolic_pkg constants.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_arst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 i_valid  input  1  operand pair on i_a/i_b is valid.
REQ-005 o_ready  output  1  feeder can accept an operand pair.
REQ-006 i_a  input  [3:0][3:0][7:0]  matrix A, i_a[i][k] = A row i, col k, unsigned.
REQ-007 i_b  input  [3:0][3:0][7:0]  matrix B, i_b[k][j] = B row k, col j, unsigned.
REQ-008 o_row  output  [3:0][6:0][7:0]  skewed row streams for the systolic array row inputs.
REQ-009 o_col  output  [3:0][6:0][7:0]  skewed column streams for the systolic array column inputs.
REQ-010 o_doProcess  output  1  array enable; high for every streaming cycle.
REQ-011 o_done  output  1  one-cycle pulse; array results are final.

Function
REQ-012 States: IDLE, STREAM, DONE; state enum is one-hot or binary at implementer's choice.
REQ-013 IDLE: o_ready=1, o_doProcess=0; i_valid=1 -> capture, state STREAM, cycle counter cnt=0.
REQ-014 Capture: row lane i slot s <= A[i][s-i] when i<=s<=i+3, else 0.
REQ-015 Capture: col lane j slot s <= B[s-j][j] when j<=s<=j+3, else 0.
REQ-016 o_row/o_col always drive the lane registers directly (no output mux); slot 0 is the array-facing element.
REQ-017 STREAM: o_ready=0, o_doProcess=1; each cycle every lane shifts slot s <= slot s+1, slot 6 <= 0; cnt increments.
REQ-018 STREAM lasts exactly PROCESS_CYCLES = 10 cycles (cnt 0..9); at cnt=9 next state DONE.
REQ-019 Slots 0..6 present operands for cycles 0..6; cycles 7..9 present zeros so the last products propagate to PE[3][3].
REQ-020 DONE: o_done=1 for exactly one cycle, o_doProcess=0, o_ready=0, lanes hold zero; next state IDLE.
REQ-021 i_valid while o_ready=0 is ignored; i_a/i_b are not sampled; no queueing.
REQ-022 Back-to-back: earliest next accept is the cycle after DONE; accept-to-accept period is 12 cycles.
REQ-023 i_a/i_b may change after the accept cycle without affecting the streams.
REQ-024 Counter width: 4 bits; no wrap occurs because STREAM exits at 9.

Reset
REQ-025 i_arst=0 asynchronously forces IDLE, cnt=0, all lane slots 0.
REQ-026 Reset values: o_row=0, o_col=0, o_doProcess=0, o_done=0, o_ready=1 (as soon as reset deasserts).
REQ-027 Reset mid-STREAM aborts the operation: no o_done, lanes zero; the next i_valid after release starts a fresh pass.

Structure
REQ-028 systolic_pkg holds N=4, DATA_W=8, LANE_LEN=2N-1=7, PROCESS_CYCLES=3N-2=10, and the feeder state typedef.
REQ-029 One sub-module, feeder_lane: a LANE_LEN x DATA_W parallel-load, shift-toward-slot-0, zero-fill register; instantiated 8 times (4 row, 4 col).
REQ-030 The FSM and counter live in systolic_feeder; lane load data (skew mapping) is formed combinationally in systolic_feeder.

Verification
REQ-031 A[i][k]=16i+k, B=0, accept at cycle T -> cycle T+1: o_row[1][0]=0x00, o_row[1][1]=0x10, o_row[0][0]=0x00; cycle T+2: o_row[1][0]=0x10, o_row[3][0]=0x00; cycle T+4: o_row[3][0]=0x30.
REQ-032 A=identity, B[k][j]=4k+j, feeder driving a systolicArray -> after o_done, every C[i][j]=4i+j; o_doProcess high for exactly 10 cycles.
REQ-033 A all 1, B all 2 -> o_done exactly 11 cycles after the accept edge; every C[i][j]=8.
REQ-034 i_valid held high continuously with changing data -> accepts only when o_ready=1, every 12 cycles; the second pass streams its own captured data.
REQ-035 i_arst pulsed low at cnt=5 -> outputs zero immediately (asynchronous), no o_done, o_ready=1 after release, next pass correct.
REQ-036 Column-lane check: B[k][j]=16k+j -> o_col[2][0..1]=0,0; o_col[2][2]=0x02, o_col[2][5]=0x32, o_col[2][6]=0 at cycle T+1.
